// File: rtl/branch_target_predictor_pkg.sv
// Shared types for the branch target predictor: direction-counter encoding
// and sweep FSM states.
package branch_target_predictor_pkg;

   typedef enum logic [1:0] {
      StrongNT = 2'b00,
      WeakNT   = 2'b01,
      WeakT    = 2'b10,
      StrongT  = 2'b11
   } ctrState;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } bpState;

endpackage

// File: rtl/branch_target_predictor_sat_counter2.sv
// Combinational next state of a 2-bit saturating direction counter.
module sat_counter2
   import branch_target_predictor_pkg::*;
(
   input  ctrState ctr,
   input  logic    taken,
   output ctrState ctr_next
);

   always_comb begin
      ctr_next = ctr;
      unique case (ctr)
         StrongNT: ctr_next = taken ? WeakNT  : StrongNT;
         WeakNT:   ctr_next = taken ? WeakT   : StrongNT;
         WeakT:    ctr_next = taken ? StrongT : WeakNT;
         StrongT:  ctr_next = taken ? StrongT : WeakT;
         default:  ctr_next = WeakNT;
      endcase
   end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, trained at resolution,
// with a one-entry-per-cycle invalidation sweep.
module branch_target_predictor
   import branch_target_predictor_pkg::*;
#(
   parameter int BIT_COUNT = 32,
   parameter int ENTRIES   = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [BIT_COUNT-1:0] PC_I,
   output logic                 Predict,
   output logic [BIT_COUNT-1:0] Prediction,
   input  logic                 Resolve_C,
   input  logic [BIT_COUNT-1:0] ResolvePC_C,
   input  logic                 Taken_C,
   input  logic [BIT_COUNT-1:0] Target_C,
   input  logic                 PredictedTaken_C,
   input  logic [BIT_COUNT-1:0] PredictedTarget_C,
   output logic                 PredictionCorrect_C,
   input  logic                 InvalidateAll,
   output logic                 Busy,
   output logic [15:0]          MispredictCount
);

   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = BIT_COUNT - IDX - 2;
   localparam logic [IDX-1:0] LAST = IDX'(ENTRIES - 1);

   typedef struct packed {
      logic                 valid;
      logic [TAG_W-1:0]     tag;
      logic [BIT_COUNT-1:0] target;
      ctrState              ctr;
   } entry_t;

   entry_t          btb_q [ENTRIES];
   bpState          state_q, state_d;
   logic [IDX-1:0]  ptr_q;

   logic [IDX-1:0]  lk_idx, rs_idx;
   logic [TAG_W-1:0] lk_tag, rs_tag;
   entry_t          lk_entry, rs_entry;
   logic            rs_hit;
   ctrState         ctr_next;
   logic            unused_pc_bits;

   assign unused_pc_bits = &{1'b0, PC_I[1:0], ResolvePC_C[1:0]};

   // Lookup
   assign lk_idx   = PC_I[IDX+1:2];
   assign lk_tag   = PC_I[BIT_COUNT-1:IDX+2];
   assign lk_entry = btb_q[lk_idx];

   always_comb begin
      Predict    = !Busy && lk_entry.valid && (lk_entry.tag == lk_tag) && lk_entry.ctr[1];
      Prediction = Predict ? lk_entry.target : '0;
   end

   // Resolution
   assign rs_idx   = ResolvePC_C[IDX+1:2];
   assign rs_tag   = ResolvePC_C[BIT_COUNT-1:IDX+2];
   assign rs_entry = btb_q[rs_idx];
   assign rs_hit   = rs_entry.valid && (rs_entry.tag == rs_tag);

   assign PredictionCorrect_C = Resolve_C && (Taken_C == PredictedTaken_C) &&
                                (!Taken_C || (Target_C == PredictedTarget_C));

   sat_counter2 u_ctr (
      .ctr      (rs_entry.ctr),
      .taken    (Taken_C),
      .ctr_next (ctr_next)
   );

   // Sweep writes and training are exclusive: training is dropped while busy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WeakNT};
         end
      end else if (Busy) begin
         btb_q[ptr_q].valid <= 1'b0;
         btb_q[ptr_q].ctr   <= WeakNT;
      end else if (Resolve_C) begin
         if (rs_hit) begin
            btb_q[rs_idx].ctr <= ctr_next;
            if (Taken_C) btb_q[rs_idx].target <= Target_C;
         end else if (Taken_C) begin
            btb_q[rs_idx] <= '{valid: 1'b1, tag: rs_tag, target: Target_C, ctr: WeakT};
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (InvalidateAll) state_d = CLEAR;
         CLEAR:   if (ptr_q == LAST) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      Busy = (state_q == CLEAR);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                           ptr_q <= '0;
      else if (state_q == IDLE && InvalidateAll) ptr_q <= '0;
      else if (state_q == CLEAR)              ptr_q <= ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         MispredictCount <= '0;
      else if (Resolve_C && !PredictionCorrect_C && MispredictCount != 16'hFFFF)
         MispredictCount <= MispredictCount + 16'd1;
   end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed self-checking bench for branch_target_predictor (32-bit PC, 16 entries).
module tb_branch_target_predictor;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] PC_I;
   logic        Predict;
   logic [31:0] Prediction;
   logic        Resolve_C;
   logic [31:0] ResolvePC_C;
   logic        Taken_C;
   logic [31:0] Target_C;
   logic        PredictedTaken_C;
   logic [31:0] PredictedTarget_C;
   logic        PredictionCorrect_C;
   logic        InvalidateAll;
   logic        Busy;
   logic [15:0] MispredictCount;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   branch_target_predictor #(.BIT_COUNT(32), .ENTRIES(16)) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .PC_I                (PC_I),
      .Predict             (Predict),
      .Prediction          (Prediction),
      .Resolve_C           (Resolve_C),
      .ResolvePC_C         (ResolvePC_C),
      .Taken_C             (Taken_C),
      .Target_C            (Target_C),
      .PredictedTaken_C    (PredictedTaken_C),
      .PredictedTarget_C   (PredictedTarget_C),
      .PredictionCorrect_C (PredictionCorrect_C),
      .InvalidateAll       (InvalidateAll),
      .Busy                (Busy),
      .MispredictCount     (MispredictCount)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one resolution for the next edge; returns after the edge with Resolve_C cleared.
   task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt, input logic exp_ok,
                          input string tag);
      Resolve_C = 1'b1; ResolvePC_C = pc; Taken_C = tk; Target_C = tgt;
      PredictedTaken_C = ptk; PredictedTarget_C = ptgt;
      #1;
      check_val({tag, "_correct"}, 32'(PredictionCorrect_C), 32'(exp_ok));
      tick();
      Resolve_C = 1'b0;
      #1;
   endtask

   task automatic look(input logic [31:0] pc, input logic exp_p, input logic [31:0] exp_t,
                       input string tag);
      PC_I = pc;
      #1;
      check_val({tag, "_predict"}, 32'(Predict), 32'(exp_p));
      check_val({tag, "_target"}, Prediction, exp_t);
   endtask

   initial begin
      reset_n = 1'b0; PC_I = 32'h100; Resolve_C = 1'b0; ResolvePC_C = '0; Taken_C = 1'b0;
      Target_C = '0; PredictedTaken_C = 1'b0; PredictedTarget_C = '0; InvalidateAll = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_busy", 32'(Busy), 32'd0);
      reset_n = 1'b1;
      tick();

      look(32'h100, 1'b0, 32'h0, "idle");
      check_val("idle_busy", 32'(Busy), 32'd0);
      check_val("idle_cnt", 32'(MispredictCount), 32'd0);

      // Correctness is gated by Resolve_C
      Taken_C = 1'b0; PredictedTaken_C = 1'b0;
      #1;
      check_val("noresolve_correct", 32'(PredictionCorrect_C), 32'd0);

      // Allocation; same-cycle lookup sees the old (empty) entry
      PC_I = 32'h100;
      Resolve_C = 1'b1; ResolvePC_C = 32'h100; Taken_C = 1'b1; Target_C = 32'h200;
      PredictedTaken_C = 1'b0; PredictedTarget_C = '0;
      #1;
      check_val("alloc_correct", 32'(PredictionCorrect_C), 32'd0);
      check_val("alloc_same_cycle", 32'(Predict), 32'd0);
      tick();
      Resolve_C = 1'b0;
      check_val("alloc_cnt", 32'(MispredictCount), 32'd1);
      look(32'h100, 1'b1, 32'h200, "alloc");

      // Counter down: 10 -> 01 -> 00 -> 00
      resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, "nt1");
      look(32'h100, 1'b0, 32'h0, "ctr01");
      resolve(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "nt2");
      resolve(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "nt3");
      check_val("nt_cnt", 32'(MispredictCount), 32'd2);
      // Counter up: 00 -> 01 -> 10 -> 11
      resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, "t1");
      look(32'h100, 1'b0, 32'h0, "ctr_up01");
      resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, "t2");
      look(32'h100, 1'b1, 32'h200, "ctr_up10");
      resolve(32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, "t3");
      resolve(32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, "t4_sat");
      // 11 saturated, so one not-taken still leaves it predicting taken
      resolve(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "nt_from11");
      look(32'h100, 1'b1, 32'h200, "ctr10_again");
      check_val("up_cnt", 32'(MispredictCount), 32'd4);

      // Wrong target counts as mispredict and retrains the target
      resolve(32'h100, 1'b1, 32'h300, 1'b1, 32'h200, 1'b0, "bad_tgt");
      look(32'h100, 1'b1, 32'h300, "retarget");
      check_val("tgt_cnt", 32'(MispredictCount), 32'd5);

      // Alias: same index, different tag
      look(32'h140, 1'b0, 32'h0, "alias");
      resolve(32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "alias_nt");
      look(32'h100, 1'b1, 32'h300, "alias_intact");

      resolve(32'h104, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, "alloc104");
      look(32'h104, 1'b1, 32'h500, "idx1");
      check_val("pre_sweep_cnt", 32'(MispredictCount), 32'd6);

      // Sweep
      PC_I = 32'h100;
      InvalidateAll = 1'b1;
      #1;
      check_val("sweep_t_busy", 32'(Busy), 32'd0);
      tick();
      InvalidateAll = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         Resolve_C = (k == 12); ResolvePC_C = 32'h108; Taken_C = 1'b1; Target_C = 32'h700;
         PredictedTaken_C = 1'b0; PredictedTarget_C = '0;
         InvalidateAll = (k == 5);
         #1;
         check_val($sformatf("sweep_busy_%0d", k), 32'(Busy), 32'd1);
         check_val($sformatf("sweep_pred_%0d", k), 32'(Predict), 32'd0);
         tick();
      end
      Resolve_C = 1'b0; InvalidateAll = 1'b0;
      #1;
      check_val("sweep_end_busy", 32'(Busy), 32'd0);
      check_val("sweep_cnt", 32'(MispredictCount), 32'd7);
      for (int i = 0; i < 16; i++) begin
         look(32'h100 + 32'(4 * i), 1'b0, 32'h0, $sformatf("after_sweep_%0d", i));
      end

      // Saturation of the mispredict counter
      Resolve_C = 1'b1; ResolvePC_C = 32'h200; Taken_C = 1'b0; PredictedTaken_C = 1'b1;
      repeat (70000) @(posedge clk);
      #1;
      Resolve_C = 1'b0;
      check_val("cnt_sat", 32'(MispredictCount), 32'hFFFF);
      tick();
      check_val("cnt_sat_hold", 32'(MispredictCount), 32'hFFFF);

      // Reset in the middle of a sweep
      resolve(32'h13C, 1'b1, 32'h900, 1'b0, 32'h0, 1'b0, "alloc13c");
      look(32'h13C, 1'b1, 32'h900, "idx15");
      InvalidateAll = 1'b1;
      tick();
      InvalidateAll = 1'b0;
      repeat (3) tick();
      check_val("mid_sweep_busy", 32'(Busy), 32'd1);
      reset_n = 1'b0;
      #1;
      check_val("rst_mid_busy", 32'(Busy), 32'd0);
      check_val("rst_mid_cnt", 32'(MispredictCount), 32'd0);
      look(32'h13C, 1'b0, 32'h0, "rst_mid");
      tick();
      reset_n = 1'b1;
      tick();
      check_val("post_rst_busy", 32'(Busy), 32'd0);
      look(32'h13C, 1'b0, 32'h0, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
